// File: rtl/segre_mem_stage.sv
// Segre MEM stage: EX/MEM register, req/gnt/rvalid data-memory port, store lane alignment, load extension.
// Optional misaligned-access trap enabled by defining SEGRE_MEM_MISALIGN_TRAP_EN.
module segre_mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_SIZE  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_ex_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  logic [1:0]           memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic                 is_jaljalr_i,
  input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
  input  logic                 block_mem_i,
  input  logic                 inject_nops_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_SIZE-1:0] dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [WORD_SIZE-1:0] dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 valid_mem_o,
  output logic                 mem_stall_o,
  output logic                 misalign_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;

  logic                 valid_q;
  logic [WORD_SIZE-1:0] alu_res_q;
  logic                 rf_we_q;
  logic [REG_SIZE-1:0]  rf_waddr_q;
  logic [WORD_SIZE-1:0] st_data_q;
  logic [1:0]           type_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 sext_q;
  logic                 jal_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] ld_q;
  state_e               state_q, state_d;

  logic                 hold;
  logic                 is_store;
  logic                 misalign;
  logic                 active;
  logic                 req;
  logic [1:0]           lsb;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata;
  logic [7:0]           lane8;
  logic [15:0]          lane16;
  logic [WORD_SIZE-1:0] ld_ext;

  assign hold     = block_mem_i | mem_stall_o;
  assign lsb      = alu_res_q[1:0];
  assign is_store = wr_q & ~rd_q;

`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
  assign misalign = valid_q & (rd_q | wr_q) &
                    (((type_q == MEM_HALF) & lsb[0]) |
                     ((type_q != MEM_BYTE) & (type_q != MEM_HALF) & (lsb != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign active = valid_q & (rd_q | wr_q) & ~misalign;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      alu_res_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      st_data_q  <= '0;
      type_q     <= 2'b00;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      sext_q     <= 1'b0;
      jal_q      <= 1'b0;
      pc_q       <= '0;
    end else if (!hold) begin
      if (inject_nops_i) begin
        valid_q <= 1'b0;
        rf_we_q <= 1'b0;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
      end else begin
        valid_q    <= valid_ex_i;
        alu_res_q  <= alu_res_i;
        rf_we_q    <= rf_we_i;
        rf_waddr_q <= rf_waddr_i;
        st_data_q  <= rf_st_data_i;
        type_q     <= memop_type_i;
        rd_q       <= memop_rd_i;
        wr_q       <= memop_wr_i;
        sext_q     <= memop_sign_ext_i;
        jal_q      <= is_jaljalr_i;
        pc_q       <= seq_new_pc_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && dmem_rvalid_i) begin
        ld_q <= dmem_rdata_i;
      end
    end
  end

  // DONE is left only when the stage register advances (capture or bubble).
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          req = 1'b1;
          if (dmem_gnt_i && rd_q) state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) state_d = DONE;
      end
      DONE: begin
        if (!hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall_o = active & ~(is_store & dmem_gnt_i) & (state_q != DONE);
  assign valid_mem_o = valid_q & ~mem_stall_o;
  assign rf_we_o     = rf_we_q & valid_mem_o & ~misalign;
  assign rf_waddr_o  = rf_waddr_q;
  assign misalign_o  = misalign;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data_q;
    case (type_q)
      MEM_BYTE: begin
        be    = 4'b0001 << lsb;
        wdata = {(WORD_SIZE/8){st_data_q[7:0]}};
      end
      MEM_HALF: begin
        be    = 4'b0011 << {lsb[1], 1'b0};
        wdata = {(WORD_SIZE/16){st_data_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data_q;
      end
    endcase
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = req & is_store;
  assign dmem_be_o    = req ? be : 4'b0000;
  assign dmem_addr_o  = {alu_res_q[ADDR_SIZE-1:2], 2'b00};
  assign dmem_wdata_o = wdata;

  assign lane8  = ld_q[{lsb, 3'b000} +: 8];
  assign lane16 = ld_q[{lsb[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = ld_q;
    case (type_q)
      MEM_BYTE: ld_ext = {{(WORD_SIZE-8){sext_q & lane8[7]}}, lane8};
      MEM_HALF: ld_ext = {{(WORD_SIZE-16){sext_q & lane16[15]}}, lane16};
      default:  ld_ext = ld_q;
    endcase
  end

  always_comb begin
    rf_wdata_o = alu_res_q;
    if (rd_q) begin
      rf_wdata_o = ld_ext;
    end else if (jal_q) begin
      rf_wdata_o = WORD_SIZE'(pc_q);
    end
  end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Self-checking bench for segre_mem_stage: directed vector table, hand-written corner sequences,
// and randomized transactions checked against an arithmetic reference model.
module tb_segre_mem_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_ex_i = 1'b0;
  logic [31:0] alu_res_i = '0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_waddr_i = '0;
  logic [31:0] rf_st_data_i = '0;
  logic [1:0]  memop_type_i = '0;
  logic        memop_rd_i = 1'b0;
  logic        memop_wr_i = 1'b0;
  logic        memop_sign_ext_i = 1'b0;
  logic        is_jaljalr_i = 1'b0;
  logic [31:0] seq_new_pc_i = '0;
  logic        block_mem_i = 1'b0;
  logic        inject_nops_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        valid_mem_o, mem_stall_o, misalign_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  segre_mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .valid_ex_i(valid_ex_i), .alu_res_i(alu_res_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i),
    .memop_type_i(memop_type_i), .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
    .memop_sign_ext_i(memop_sign_ext_i), .is_jaljalr_i(is_jaljalr_i),
    .seq_new_pc_i(seq_new_pc_i), .block_mem_i(block_mem_i), .inject_nops_i(inject_nops_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .valid_mem_o(valid_mem_o),
    .mem_stall_o(mem_stall_o), .misalign_o(misalign_o)
  );

  // kind: 0 alu, 1 jal, 2 load, 3 store, 4 load+store flags (behaves as load)
  typedef struct packed {
    int          kind;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  typ;
    logic        sext;
    logic        we;
    logic [4:0]  waddr;
    int          gd;
    int          rvd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_res;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic txn_t mk(input int kind, input logic [31:0] addr, input logic [31:0] st,
                              input logic [1:0] typ, input logic sext, input logic we,
                              input logic [4:0] waddr, input logic [31:0] pc,
                              input logic [31:0] rdata, input int gd, input int rvd,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] eres);
    txn_t t;
    t.kind = kind; t.addr = addr; t.st = st; t.typ = typ; t.sext = sext; t.we = we;
    t.waddr = waddr; t.pc = pc; t.rdata = rdata; t.gd = gd; t.rvd = rvd;
    t.exp_addr = ea; t.exp_be = ebe; t.exp_wdata = ewd; t.exp_res = eres;
    return t;
  endfunction

  // Reference model: expected results from the access rules using plain arithmetic.
  function automatic txn_t model(input txn_t t);
    int a;
    logic [31:0] v;
    a = int'(t.addr[1:0]);
    t.exp_addr = t.addr & 32'hFFFF_FFFC;
    if (t.typ == 2'd0) begin
      t.exp_be    = 4'(1 << a);
      t.exp_wdata = {24'h0, t.st[7:0]} * 32'h0101_0101;
      v = (t.rdata >> (8 * a)) & 32'hFF;
      if (t.sext && v[7]) v = v | 32'hFFFF_FF00;
    end else if (t.typ == 2'd1) begin
      t.exp_be    = 4'(3 << (a & 2));
      t.exp_wdata = {16'h0, t.st[15:0]} * 32'h0001_0001;
      v = (t.rdata >> (16 * (a / 2))) & 32'hFFFF;
      if (t.sext && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      t.exp_be    = 4'hF;
      t.exp_wdata = t.st;
      v = t.rdata;
    end
    if (t.kind == 2 || t.kind == 4) t.exp_res = v;
    else if (t.kind == 1) t.exp_res = t.pc;
    else t.exp_res = t.addr;
    return t;
  endfunction

  task automatic drive_instr(input txn_t t);
    valid_ex_i       = 1'b1;
    alu_res_i        = t.addr;
    rf_we_i          = t.we;
    rf_waddr_i       = t.waddr;
    rf_st_data_i     = t.st;
    memop_type_i     = t.typ;
    memop_rd_i       = (t.kind == 2 || t.kind == 4);
    memop_wr_i       = (t.kind == 3 || t.kind == 4);
    memop_sign_ext_i = t.sext;
    is_jaljalr_i     = (t.kind == 1);
    seq_new_pc_i     = t.pc;
  endtask

  // Inputs change to junk while the stage holds, so holding is exercised too.
  task automatic clear_instr();
    valid_ex_i   = 1'b0;
    rf_we_i      = 1'b0;
    memop_rd_i   = 1'b0;
    memop_wr_i   = 1'b0;
    is_jaljalr_i = 1'b0;
    alu_res_i    = $urandom;
    rf_st_data_i = $urandom;
    seq_new_pc_i = $urandom;
  endtask

  task automatic run_txn(input txn_t t);
    bit is_ld, is_st, is_mem, mis, exp_req;
    int done_cyc;
    is_ld = (t.kind == 2 || t.kind == 4);
    is_st = (t.kind == 3);
    mis = 1'b0;
`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
    mis = (is_ld || is_st) && ((t.typ == 2'd1 && t.addr[0]) || (t.typ == 2'd2 && t.addr[1:0] != 2'b00));
`endif
    is_mem = (is_ld || is_st) && !mis;
    done_cyc = (is_mem && is_st) ? t.gd : (is_mem && is_ld) ? t.gd + t.rvd + 1 : 0;
    drive_instr(t);
    @(posedge clk); #1;
    clear_instr();
    for (int c = 0; c <= done_cyc; c++) begin
      dmem_gnt_i    = is_mem && (c == t.gd || (is_ld && c > t.gd && $urandom_range(0, 1) == 1));
      dmem_rvalid_i = is_mem && is_ld && (c == t.gd + t.rvd || (c < t.gd && $urandom_range(0, 1) == 1));
      dmem_rdata_i  = (c == t.gd + t.rvd) ? t.rdata : $urandom;
      @(negedge clk);
      exp_req = is_mem && c <= t.gd;
      chk("req", 32'(dmem_req_o), 32'(exp_req));
      if (exp_req && c == t.gd) begin
        chk("addr", dmem_addr_o, t.exp_addr);
        chk("be", 32'(dmem_be_o), 32'(t.exp_be));
        chk("we", 32'(dmem_we_o), 32'(is_st));
        if (is_st) chk("wdata", dmem_wdata_o, t.exp_wdata);
      end
      if (c < done_cyc) chk("stall_valid", 32'({mem_stall_o, valid_mem_o}), 32'h2);
      else begin
        chk("done_stall_valid", 32'({mem_stall_o, valid_mem_o}), 32'h1);
        chk("rf_we", 32'(rf_we_o), 32'(t.we && !mis));
        chk("misalign", 32'(misalign_o), 32'(mis));
        if (!mis) begin
          chk("rf_waddr", 32'(rf_waddr_o), 32'(t.waddr));
          chk("rf_wdata", rf_wdata_o, t.exp_res);
        end
      end
      @(posedge clk); #1;
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  txn_t vec [8];
  txn_t rt;

  initial begin
    vec[0] = mk(0, 32'h1234, 0, 2'd2, 0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 32'h1234);
    vec[1] = mk(3, 32'h103, 32'hAB, 2'd0, 0, 0, 1, 0, 0, 2, 1, 32'h100, 4'b1000, 32'hABABABAB, 32'h103);
    vec[2] = mk(2, 32'h101, 0, 2'd0, 1, 1, 7, 0, 32'h8000, 0, 3, 32'h100, 4'b0010, 0, 32'hFFFFFF80);
    vec[3] = mk(2, 32'h101, 0, 2'd0, 0, 1, 8, 0, 32'h8000, 0, 3, 32'h100, 4'b0010, 0, 32'h80);
    vec[4] = mk(1, 32'h999, 0, 2'd2, 0, 1, 1, 32'h44, 0, 0, 1, 0, 0, 0, 32'h44);
    vec[5] = mk(2, 32'h102, 0, 2'd2, 0, 1, 9, 0, 32'h11223344, 1, 1, 32'h100, 4'b1111, 0, 32'h11223344);
    vec[6] = mk(3, 32'h2, 32'h1234ABCD, 2'd1, 0, 0, 2, 0, 0, 0, 1, 32'h0, 4'b1100, 32'hABCDABCD, 32'h2);
    vec[7] = mk(2, 32'h3, 0, 2'd1, 1, 1, 3, 0, 32'h80001234, 1, 2, 32'h0, 4'b1100, 0, 32'hFFFF8000);

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        32'({dmem_req_o, dmem_we_o, dmem_be_o, rf_we_o, valid_mem_o, mem_stall_o, misalign_o}), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn(vec[i]);

    // Bubble injection: neither an ALU op nor a load reaches WB or the memory port.
    rt = model(mk(2, 32'h40, 0, 2'd2, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0));
    drive_instr(rt);
    inject_nops_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("nop_out", 32'({valid_mem_o, rf_we_o, dmem_req_o, mem_stall_o}), 32'h0);
    @(posedge clk); #1;
    inject_nops_i = 1'b0;
    clear_instr();

    // Reset while waiting for read data; the late rvalid must be ignored.
    rt = model(mk(2, 32'h80, 0, 2'd2, 0, 1, 6, 0, 0, 0, 1, 0, 0, 0, 0));
    drive_instr(rt);
    @(posedge clk); #1;
    clear_instr();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_wait_req", 32'(dmem_req_o), 32'h1);
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_wait_stall", 32'(mem_stall_o), 32'h1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_rvalid_ignored", 32'({mem_stall_o, valid_mem_o, dmem_req_o}), 32'h0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rst_after", 32'({mem_stall_o, valid_mem_o, rf_we_o}), 32'h0);
    @(posedge clk); #1;

    // block_mem_i holds a completed load in DONE, then the next instruction enters.
    rt = model(mk(2, 32'h0, 0, 2'd2, 0, 1, 10, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0));
    drive_instr(rt);
    @(posedge clk); #1;
    clear_instr();
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    block_mem_i = 1'b1;
    drive_instr(model(mk(0, 32'h55, 0, 2'd2, 0, 1, 11, 0, 0, 0, 1, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("blk_done_valid", 32'({valid_mem_o, mem_stall_o, rf_we_o}), 32'h5);
      chk("blk_done_data", rf_wdata_o, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    block_mem_i = 1'b0;
    @(posedge clk); #1;
    clear_instr();
    @(negedge clk);
    chk("blk_next_data", rf_wdata_o, 32'h55);
    chk("blk_next_addr", 32'(rf_waddr_o), 32'd11);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      rt = mk(int'($urandom_range(0, 4)), $urandom, $urandom, 2'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 0, 0, 0, 0);
      run_txn(model(rt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/segre_mem_stage.md
Name: segre_mem_stage

Overview:
- Memory stage of the Segre in-order pipeline. It consumes the EX/MEM interface: ALU result, register-file write control, store data, memop controls and jal/jalr link PC.
- It registers that interface, drives a request/grant/rvalid data-memory port, aligns store data and sign/zero-extends loads.
- It presents a single write-back result to WB and stalls upstream stages while a memory access is outstanding.

Parameters:
- WORD_SIZE, 32, data/ALU width.
- ADDR_SIZE, 32, address/PC width.
- REG_SIZE, 5, register index width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_ex_i  in  1  EX holds a valid instruction.
- alu_res_i  in  WORD_SIZE  ALU result; effective address for memops.
- rf_we_i  in  1  register-file write enable.
- rf_waddr_i  in  REG_SIZE  destination register.
- rf_st_data_i  in  WORD_SIZE  store data.
- memop_type_i  in  2  memop_data_type_e: 00 byte, 01 half, 10 word.
- memop_rd_i  in  1  load.
- memop_wr_i  in  1  store.
- memop_sign_ext_i  in  1  sign-extend load.
- is_jaljalr_i  in  1  write link PC.
- seq_new_pc_i  in  ADDR_SIZE  pc+4.
- block_mem_i  in  1  hold stage register.
- inject_nops_i  in  1  capture a bubble.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  ADDR_SIZE  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  WORD_SIZE  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  WORD_SIZE  read data.
- rf_we_o  out  1  WB write enable.
- rf_waddr_o  out  REG_SIZE  WB destination.
- rf_wdata_o  out  WORD_SIZE  WB data.
- valid_mem_o  out  1  instruction completes this cycle.
- mem_stall_o  out  1  stall IF/ID/EX.
- misalign_o  out  1  misaligned access (macro only; tied 0 otherwise).

Behaviour:
- Reset: valid_q=0, FSM=IDLE. All outputs are 0: dmem_req_o, dmem_we_o, dmem_be_o, rf_we_o, valid_mem_o, mem_stall_o, misalign_o.
- Reset mid-access: drops the request. An rvalid arriving after reset is ignored.
- Stage register priority per edge:
  - rst_i.
  - Then hold if block_mem_i or mem_stall_o.
  - Else bubble (valid_q=0, rf_we_q/rd_q/wr_q=0) if inject_nops_i.
  - Else capture all inputs.
- Active memop = valid_q & (rd_q | wr_q). If rd_q and wr_q are both set, the access is a load.
- FSM states: IDLE, WAIT, DONE.
- IDLE with active memop:
  - dmem_req_o=1 combinationally, held until dmem_gnt_i.
  - Store and gnt: completes that cycle; stays IDLE.
  - Load and gnt: goes to WAIT.
- WAIT: dmem_req_o=0. dmem_gnt_i is ignored. On dmem_rvalid_i, latch dmem_rdata_i into ld_q and go to DONE.
- DONE: load completes. Goes to IDLE when the next instruction is captured or a bubble is taken; remains DONE while block_mem_i.
- rvalid outside WAIT is ignored.
- mem_stall_o = active memop & ~(store & gnt) & state!=DONE.
- valid_mem_o = valid_q & ~mem_stall_o.
- rf_we_o = rf_we_q & valid_mem_o.
- Non-memop instructions complete in the cycle they occupy the stage (0 extra latency). Load minimum: gnt in cycle N, rvalid in N+1, completes in N+2.
- rf_wdata_o selection:
  - load: extended ld_q.
  - is_jaljalr_q: seq_new_pc_q.
  - else: alu_res_q.
- Byte enables and store data, with a = alu_res_q[1:0]:
  - byte: be = 0001<<a; wdata = {4{st[7:0]}}.
  - half: be = 0011<<{a[1],0}; wdata = {2{st[15:0]}}.
  - word: be = 1111; wdata = st.
- Load extraction: select the byte/half lane at a (half uses a[1]). Sign-extend if sign_ext_q, else zero-extend.
- valid_q=0 with rd/wr set: no request, no stall.

Optional Feature:
- Macro: SEGRE_MEM_MISALIGN_TRAP_EN.
- Enabled:
  - half with a[0]=1, or word with a!=00, issues no request and does not stall.
  - misalign_o=1 and valid_mem_o=1 in that cycle; rf_we_o forced 0.
- Disabled: misalign_o tied 0. Low address bits outside the access size are ignored (half uses a[1]; word uses 00).

Test Plan:
- Reset during WAIT, then rvalid next cycle -> FSM IDLE, no stall, valid_mem_o=0, rvalid ignored.
- ALU op, alu_res_i=0x1234, rf_waddr_i=5, rf_we_i=1 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234, stall 0.
- Store byte at 0x103, data 0xAB, gnt after 2 cycles:
  - dmem_be_o=1000, dmem_addr_o=0x100, wdata=0xABABABAB.
  - stall 2 cycles; completes on gnt.
- Signed byte load at 0x101, rdata=0x00008000, gnt immediately, rvalid 3 cycles later:
  - rf_wdata_o=0xFFFFFF80, valid 1 cycle after rvalid.
  - Unsigned: 0x00000080.
- jal, seq_new_pc_i=0x44 -> rf_wdata_o=0x44. inject_nops_i -> valid_mem_o=0, rf_we_o=0, no request.
- Macro on, word load at 0x102 -> misalign_o=1, dmem_req_o=0, rf_we_o=0. Macro off -> dmem_addr_o=0x100, be=1111.
